// File: rtl/cache_arb_pkg.sv
// Shared types and the round-robin search helper for the cache request arbiter.
// Request IDs are sized for the largest supported requester count.
package cache_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int IDW      = $clog2(MAX_NREQ);

  typedef logic [IDW-1:0] req_id_t;

  typedef struct packed {
    logic    found;
    req_id_t idx;
  } pick_t;

  // First set bit of vld[n-1:0] at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] vld,
                                    input req_id_t             ptr,
                                    input int                  n);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !res.found && vld[j[IDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_arb_idfifo.sv
// In-order FIFO of granted requester IDs; one entry per outstanding cache request.
// Push and pop may occur in the same cycle; the caller never pushes when full or pops when empty.
module cache_arb_idfifo
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  req_id_t                push_id,
  input  logic                   pop,
  output req_id_t                head_id,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_id_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: the storage array is deliberately left unreset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_id = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/cache_req_arb.sv
// Round-robin arbiter sharing the cache controller request port between NREQ requesters,
// with an in-order ID FIFO steering each response beat back to its issuer.
module cache_req_arb
  import cache_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  output logic [NREQ-1:0]        req_rdy,
  input  logic [NREQ*AW-1:0]     req_addr,
  output logic [NREQ-1:0]        rsp_vld,
  output logic [DW-1:0]          rsp_data,
  output logic                   c_vld,
  input  logic                   c_rdy,
  output logic [AW-1:0]          c_addr,
  input  logic                   c_rsp_vld,
  input  logic [DW-1:0]          c_rsp_data,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err
);

  req_id_t               rr_ptr;
  req_id_t               lock_idx;
  req_id_t               gnt;
  req_id_t               head_id;
  logic                  lock;
  logic                  err_q;
  logic                  gnt_vld;
  logic                  hs;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [MAX_NREQ-1:0]   vld_ext;
  logic [$clog2(DEPTH):0] count;
  pick_t                 pick;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vld_ext             = '0;
    vld_ext[NREQ-1:0]   = req_vld;
    pick                = rr_pick(vld_ext, rr_ptr, NREQ);
    gnt                 = lock ? lock_idx : pick.idx;
    gnt_vld             = 1'b0;
    c_addr              = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == req_id_t'(i)) begin
        gnt_vld = req_vld[i];
        c_addr  = req_addr[i*AW +: AW];
      end
    end
  end

  // A full FIFO blocks issue even when a pop lands in the same cycle.
  assign c_vld = !rst && gnt_vld && !full;
  assign hs    = c_vld && c_rdy;
  assign pop   = !rst && c_rsp_vld && !empty;

  always_comb begin
    req_rdy = '0;
    rsp_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rdy[i] = hs  && (gnt == req_id_t'(i));
      rsp_vld[i] = pop && (head_id == req_id_t'(i));
    end
  end

  assign rsp_data    = c_rsp_data;
  assign outstanding = rst ? '0 : count;
  assign err         = err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      if (c_rsp_vld && empty) err_q <= 1'b1;
      if (hs) begin
        rr_ptr <= (gnt == req_id_t'(NREQ-1)) ? '0 : gnt + 1'b1;
        lock   <= 1'b0;
      end else if (lock && !gnt_vld) begin
        // Locked requester withdrew before acceptance.
        lock  <= 1'b0;
        err_q <= 1'b1;
      end else if (c_vld) begin
        lock     <= 1'b1;
        lock_idx <= gnt;
      end
    end
  end

  cache_arb_idfifo #(.DEPTH(DEPTH)) u_idfifo (
    .clk     (clk),
    .rst     (rst),
    .push    (hs),
    .push_id (gnt),
    .pop     (pop),
    .head_id (head_id),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_cache_req_arb.sv
// Bench for cache_req_arb: directed vector table for the corner cases, then randomized
// protocol-abiding traffic checked against a queue-based reference model.
module tb_cache_req_arb;

  localparam int NREQ  = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_vld;
  logic [NREQ-1:0]        req_rdy;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ-1:0]        rsp_vld;
  logic [DW-1:0]          rsp_data;
  logic                   c_vld;
  logic                   c_rdy;
  logic [AW-1:0]          c_addr;
  logic                   c_rsp_vld;
  logic [DW-1:0]          c_rsp_data;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   err;

  cache_req_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_addr    (req_addr),
    .rsp_vld     (rsp_vld),
    .rsp_data    (rsp_data),
    .c_vld       (c_vld),
    .c_rdy       (c_rdy),
    .c_addr      (c_addr),
    .c_rsp_vld   (c_rsp_vld),
    .c_rsp_data  (c_rsp_data),
    .outstanding (outstanding),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        crdy;
    logic        crv;
    logic [31:0] cd;
    logic [1:0]  e_rdy;
    logic        e_cv;
    logic [31:0] e_addr;
    logic [1:0]  e_rsp;
    logic [2:0]  e_occ;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [1:0] vl, input logic [31:0] x0,
                             input logic [31:0] x1, input logic cr, input logic rv,
                             input logic [31:0] d, input logic [1:0] er, input logic ecv,
                             input logic [31:0] ea, input logic [1:0] ersp,
                             input logic [2:0] eocc, input logic eerr);
    vec_t t;
    t.rst = r;   t.vld = vl;   t.a0 = x0;     t.a1 = x1;     t.crdy = cr; t.crv = rv; t.cd = d;
    t.e_rdy = er; t.e_cv = ecv; t.e_addr = ea; t.e_rsp = ersp; t.e_occ = eocc; t.e_err = eerr;
    return t;
  endfunction

  // Reference model state for the randomized phase.
  int                q[$];
  int                m_rr;
  bit                m_lock;
  int                m_lock_idx;
  bit                m_err;
  bit                pend [NREQ];
  logic [AW-1:0]     addr [NREQ];

  initial begin
    int               g;
    logic             exp_cv;
    logic [NREQ-1:0]  exp_rdy;
    logic [NREQ-1:0]  exp_rsp;

    rst = 1'b1; req_vld = '0; req_addr = '0; c_rdy = 1'b0; c_rsp_vld = 1'b0; c_rsp_data = '0;
    repeat (2) @(posedge clk);

    // Reset behaviour, then single requester.
    tbl.push_back(v(1, 2'b11, 32'h0FF001F0, 0, 1, 1, 0,            2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 32'h0FF001F0, 0, 1, 0, 0,            2'b01, 1, 32'h0FF001F0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 32'h0FF001F1, 0, 1, 1, 32'hFF0000FF, 2'b01, 1, 32'h0FF001F1, 2'b01, 1, 0));
    tbl.push_back(v(0, 2'b01, 32'h0FF001F2, 0, 1, 1, 32'hF0F0F0F0, 2'b01, 1, 32'h0FF001F2, 2'b01, 1, 0));
    tbl.push_back(v(0, 2'b01, 32'h0FF001F3, 0, 1, 1, 32'h00FFFF00, 2'b01, 1, 32'h0FF001F3, 2'b01, 1, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 1, 1, 32'h00FF00FF,            2'b00, 0, 0, 2'b01, 1, 0));
    // Alternation from a fresh reset.
    tbl.push_back(v(1, 2'b00, 0, 0, 1, 0, 0,                       2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA001F0, 32'h0BB001F0, 1, 0, 0,            2'b01, 1, 32'h0AA001F0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA001F0, 32'h0BB001F0, 1, 1, 32'h11111111, 2'b10, 1, 32'h0BB001F0, 2'b01, 1, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA001F0, 32'h0BB001F0, 1, 1, 32'h33333333, 2'b01, 1, 32'h0AA001F0, 2'b10, 1, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA001F0, 32'h0BB001F0, 1, 1, 32'h11111111, 2'b10, 1, 32'h0BB001F0, 2'b01, 1, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 1, 1, 32'h33333333,            2'b00, 0, 0, 2'b10, 1, 0));
    // Stall lock on requester 1 while requester 0 waits.
    tbl.push_back(v(0, 2'b10, 0, 32'h0BB00200, 0, 0, 0,            2'b00, 1, 32'h0BB00200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA00200, 32'h0BB00200, 0, 0, 0, 2'b00, 1, 32'h0BB00200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA00200, 32'h0BB00200, 0, 0, 0, 2'b00, 1, 32'h0BB00200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA00200, 32'h0BB00200, 1, 0, 0, 2'b10, 1, 32'h0BB00200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 32'h0AA00200, 32'h0BB00200, 1, 0, 0, 2'b01, 1, 32'h0AA00200, 2'b00, 1, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 1, 1, 32'h12345678,            2'b00, 0, 0, 2'b10, 2, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 1, 1, 32'h9ABCDEF0,            2'b00, 0, 0, 2'b01, 1, 0));
    // Fill the ID FIFO, then a pop frees exactly one slot one cycle later.
    tbl.push_back(v(0, 2'b01, 32'h0CC00000, 0, 1, 0, 0,            2'b01, 1, 32'h0CC00000, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 32'h0CC00001, 0, 1, 0, 0,            2'b01, 1, 32'h0CC00001, 2'b00, 1, 0));
    tbl.push_back(v(0, 2'b01, 32'h0CC00002, 0, 1, 0, 0,            2'b01, 1, 32'h0CC00002, 2'b00, 2, 0));
    tbl.push_back(v(0, 2'b01, 32'h0CC00003, 0, 1, 0, 0,            2'b01, 1, 32'h0CC00003, 2'b00, 3, 0));
    tbl.push_back(v(0, 2'b01, 32'h0CC00004, 0, 1, 0, 0,            2'b00, 0, 0, 2'b00, 4, 0));
    tbl.push_back(v(0, 2'b01, 32'h0CC00004, 0, 1, 1, 32'hAAAA5555, 2'b00, 0, 0, 2'b01, 4, 0));
    tbl.push_back(v(0, 2'b01, 32'h0CC00004, 0, 1, 0, 0,            2'b01, 1, 32'h0CC00004, 2'b00, 3, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 1, 1, 32'h5555AAAA,            2'b00, 0, 0, 2'b01, 4, 0));
    // Reset with three outstanding.
    tbl.push_back(v(1, 2'b01, 32'h0CC00005, 0, 1, 1, 0,            2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0,                       2'b00, 0, 0, 2'b00, 0, 0));
    // Locked requester withdraws.
    tbl.push_back(v(0, 2'b11, 32'h0DD00000, 32'h0EE00000, 0, 0, 0, 2'b00, 1, 32'h0DD00000, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b10, 32'h0DD00000, 32'h0EE00000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b10, 32'h0DD00000, 32'h0EE00000, 1, 0, 0, 2'b10, 1, 32'h0EE00000, 2'b00, 0, 1));
    // Response with an empty FIFO.
    tbl.push_back(v(1, 2'b00, 0, 0, 0, 0, 0,                       2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 1, 32'hDEADBEEF,            2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0,                       2'b00, 0, 0, 2'b00, 0, 1));

    foreach (tbl[n]) begin
      @(negedge clk);
      rst        = tbl[n].rst;
      req_vld    = tbl[n].vld;
      req_addr   = {tbl[n].a1, tbl[n].a0};
      c_rdy      = tbl[n].crdy;
      c_rsp_vld  = tbl[n].crv;
      c_rsp_data = tbl[n].cd;
      #1;
      check($sformatf("v%0d req_rdy", n),     req_rdy,     tbl[n].e_rdy);
      check($sformatf("v%0d c_vld", n),       c_vld,       tbl[n].e_cv);
      check($sformatf("v%0d rsp_vld", n),     rsp_vld,     tbl[n].e_rsp);
      check($sformatf("v%0d outstanding", n), outstanding, tbl[n].e_occ);
      check($sformatf("v%0d err", n),         err,         tbl[n].e_err);
      if (tbl[n].e_cv)
        check($sformatf("v%0d c_addr", n), c_addr, tbl[n].e_addr);
      if (tbl[n].e_rsp != 2'b00)
        check($sformatf("v%0d rsp_data", n), rsp_data, tbl[n].cd);
    end

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1'b1; req_vld = '0; c_rsp_vld = 1'b0;
    q.delete(); m_rr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; addr[i] = '0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1;
          addr[i] = $urandom;
        end
        req_vld[i]           = pend[i];
        req_addr[i*AW +: AW] = addr[i];
      end
      c_rdy      = ($urandom_range(0, 3) != 0);
      c_rsp_vld  = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      c_rsp_data = $urandom;
      #1;

      g = -1;
      if (m_lock) g = m_lock_idx;
      else
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && pend[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      exp_cv  = (g >= 0) && pend[g] && (q.size() < DEPTH);
      exp_rdy = '0;
      exp_rsp = '0;
      if (exp_cv && c_rdy) exp_rdy[g] = 1'b1;
      if (c_rsp_vld && q.size() > 0) exp_rsp[q[0]] = 1'b1;

      check($sformatf("r%0d c_vld", cyc),       c_vld,       exp_cv);
      check($sformatf("r%0d req_rdy", cyc),     req_rdy,     exp_rdy);
      check($sformatf("r%0d rsp_vld", cyc),     rsp_vld,     exp_rsp);
      check($sformatf("r%0d outstanding", cyc), outstanding, q.size());
      check($sformatf("r%0d err", cyc),         err,         m_err);
      if (exp_cv) check($sformatf("r%0d c_addr", cyc), c_addr, addr[g]);

      if (c_rsp_vld) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (exp_cv && c_rdy) begin
        q.push_back(g);
        m_rr    = (g + 1) % NREQ;
        m_lock  = 0;
        pend[g] = 0;
      end else if (m_lock && !pend[m_lock_idx]) begin
        m_lock = 0;
        m_err  = 1;
      end else if (exp_cv) begin
        m_lock     = 1;
        m_lock_idx = g;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_req_arb.md
Name: cache_req_arb

Overview:
- Round-robin arbiter that shares the single upstream request port of the cache controller between NREQ requesters (e.g. fetch and load/store).
- Records the grant index of every accepted request in an in-order ID FIFO and routes each cache response beat back to the requester that issued it.
- Sits directly in front of the cache controller upstream port. The cache returns responses strictly in request order.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 32, address width
DW, 32, response data width
DEPTH, 4, max outstanding requests (ID FIFO entries, power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_vld  in  NREQ  per-requester request valid
req_rdy  out  NREQ  per-requester request accepted this cycle
req_addr  in  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW]
rsp_vld  out  NREQ  response beat for requester i
rsp_data  out  DW  response data, broadcast to all requesters
c_vld  out  1  request valid to cache controller
c_rdy  in  1  cache controller ready
c_addr  out  AW  address to cache controller
c_rsp_vld  in  1  cache response beat
c_rsp_data  in  DW  cache response data
outstanding  out  $clog2(DEPTH)+1  current ID FIFO occupancy
err  out  1  sticky protocol error flag

Behaviour:
- Reset state: rr_ptr=0, lock=0, FIFO empty, err=0.
- Outputs during reset: req_rdy=0, rsp_vld=0, c_vld=0, outstanding=0, err=0.
- Reset mid-operation discards all outstanding IDs. The cache controller is reset on the same rst.
- Grant selection is combinational:
  - If lock=1, gnt=lock_idx.
  - Otherwise gnt is the first i with req_vld[i], searching from rr_ptr upward and wrapping modulo NREQ.
  - If no request is valid, there is no grant.
- c_vld = req_vld[gnt] && (outstanding != DEPTH). c_addr = req_addr[gnt]. Both are zero-latency pass-through.
- req_rdy[i] = (i==gnt) && c_vld && c_rdy. At most one bit of req_rdy is set.
- Handshake is c_vld && c_rdy. On handshake:
  - push gnt into the ID FIFO;
  - rr_ptr <= (gnt+1) mod NREQ;
  - lock <= 0.
- Stall hold: if c_vld && !c_rdy, then lock <= 1 and lock_idx <= gnt. The grant, c_addr and c_vld therefore stay stable until the handshake.
- Requester rules:
  - A requester must hold req_vld and req_addr stable until req_rdy.
  - If the locked requester drops req_vld, set err=1 and clear lock on the next edge.
- FIFO full (outstanding==DEPTH):
  - c_vld=0 and no grant is accepted, even if a pop occurs the same cycle. Issue resumes the cycle after the pop.
  - A stalled c_vld cannot be withdrawn by this rule, because occupancy only grows on a handshake.
- Response path is combinational:
  - rsp_vld[head]=c_rsp_vld and rsp_data=c_rsp_data; c_rsp_vld pops the FIFO.
  - Response latency through the block is 0 cycles.
- Push and pop in the same cycle (not full): occupancy is unchanged; read and write pointers both advance.
- c_rsp_vld while the FIFO is empty: err=1, all rsp_vld stay 0, no pop, pointers unchanged.
- Pointers are $clog2(DEPTH) bits wide, with wrap-around modulo DEPTH. outstanding is a separate counter ranging 0..DEPTH.
- err stays set until rst.

Decomposition:
- Package cache_arb_pkg holds:
  - localparam IDW=$clog2(NREQ);
  - typedef logic [IDW-1:0] req_id_t;
  - function rr_pick(vld, ptr), returning the first set bit at or after ptr with wrap, plus a found bit.
- One sub-module, cache_arb_idfifo: a synchronous FIFO of req_id_t, DEPTH entries, with push/pop/full/empty/count outputs. Pop and push in the same cycle are legal.
- Grant and lock logic stay in the top module.

Test Plan:
- Single requester:
  - Stimulus: req0 issues 0x0FF001F0..0x0FF001F3 with c_rdy=1. Cache returns 0xFF0000FF, 0xF0F0F0F0, 0x00FFFF00, 0x00FF00FF.
  - Required: rsp_vld[0] pulses 4 times with those values; rsp_vld[1]=0 throughout.
- Alternation:
  - Stimulus: req0 (0x0AA001F0) and req1 (0x0BB001F0) both valid continuously; cache accepts every cycle.
  - Required: grants alternate 0,1,0,1 starting with 0 after reset. Responses 0x11111111 go to req0 and 0x33333333 to req1, in issue order.
- Stall lock:
  - Stimulus: req1 granted with c_rdy=0 for 3 cycles while req0 asserts.
  - Required: c_addr stays req1's address, req_rdy[0]=0; on c_rdy=1 req1 is accepted and req0 is granted next.
- FIFO full:
  - Stimulus: 4 accepted requests with no responses.
  - Required: outstanding=4, c_vld=0 despite req_vld. After one c_rsp_vld, c_vld=1 on the following cycle and outstanding returns to 4 after the next accept.
- Error cases:
  - Stimulus (a): c_rsp_vld with the FIFO empty after reset. Required: err=1, rsp_vld=0.
  - Stimulus (b): the locked requester drops req_vld. Required: err=1 and the lock releases.
- Reset mid-flight:
  - Stimulus: assert rst with 3 outstanding.
  - Required: next cycle outstanding=0, rr_ptr=0, err=0, all outputs 0.
